// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: memory handshakes, decode inputs and PC/writeback strobes of the sequencer
interface multicycle_sequencer_if #(parameter int CNT_WIDTH = 16);
    logic                 imemReady;
    logic                 dmemReady;
    logic [4:0]           opcode;
    logic                 conditionalExecute;
    logic                 imemRead;
    logic                 irLoad;
    logic                 pcIncrement;
    logic                 pcLoadBranch;
    logic                 dmemRead;
    logic                 dmemWrite;
    logic                 aluWritebackTest;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] retiredCount;
    modport master (
        input  imemReady, dmemReady, opcode, conditionalExecute,
        output imemRead, irLoad, pcIncrement, pcLoadBranch, dmemRead, dmemWrite,
               aluWritebackTest, state, retiredCount
    );
    modport slave (
        output imemReady, dmemReady, opcode, conditionalExecute,
        input  imemRead, irLoad, pcIncrement, pcLoadBranch, dmemRead, dmemWrite,
               aluWritebackTest, state, retiredCount
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/memory/writeback control FSM with retired-instruction counter
module multicycle_sequencer #(parameter int CNT_WIDTH = 16) (
    input logic                   clk,
    input logic                   reset,
    multicycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_e;
    typedef enum logic [2:0] {C_NOP, C_ALU, C_CMP, C_BR, C_LD, C_ST} cls_e;
    state_e state_q, state_d;
    cls_e cls_q, cls_d, cls_dec;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic im_rd, ir_ld, pc_inc, pc_br, dm_rd, dm_wr, alu_wb;
    always_comb begin
        cls_dec = bus.opcode == 5'b10001 ? C_BR :
                  bus.opcode == 5'b10010 ? C_LD :
                  bus.opcode == 5'b10011 ? C_ST :
                  (bus.opcode == 5'b01010 || bus.opcode == 5'b01000) ? C_CMP :
                  bus.opcode[4] ? C_NOP : C_ALU;
    end
    always_comb begin
        state_d = state_q;
        cls_d = cls_q;
        im_rd = 1'b0;
        ir_ld = 1'b0;
        pc_inc = 1'b0;
        pc_br = 1'b0;
        dm_rd = 1'b0;
        dm_wr = 1'b0;
        alu_wb = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                im_rd = 1'b1;
                ir_ld = bus.imemReady;
                state_d = bus.imemReady ? DECODE : FETCH;
            end
            DECODE: begin
                cls_d = cls_dec;
                pc_inc = !bus.conditionalExecute;
                state_d = bus.conditionalExecute ? EXECUTE : FETCH;
            end
            EXECUTE: state_d = (cls_q == C_LD || cls_q == C_ST) ? MEMORY : WRITEBACK;
            MEMORY: begin
                dm_rd = cls_q == C_LD;
                dm_wr = cls_q == C_ST;
                state_d = bus.dmemReady ? WRITEBACK : MEMORY;
            end
            WRITEBACK: begin
                alu_wb = cls_q == C_ALU || cls_q == C_LD;
                pc_br = cls_q == C_BR;
                pc_inc = cls_q != C_BR;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cls_q <= C_NOP;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q <= cls_d;
            if (state_q == WRITEBACK) cnt_q <= cnt_q + 1'b1;
        end
    end
    assign bus.imemRead = im_rd;
    assign bus.irLoad = ir_ld;
    assign bus.pcIncrement = pc_inc;
    assign bus.pcLoadBranch = pc_br;
    assign bus.dmemRead = dm_rd;
    assign bus.dmemWrite = dm_wr;
    assign bus.aluWritebackTest = alu_wb;
    assign bus.state = state_q;
    assign bus.retiredCount = cnt_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: per-cycle trace model built from instruction latency rules, randomized instruction mix
module tb_multicycle_sequencer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    multicycle_sequencer_if #(.CNT_WIDTH(W)) bus();
    multicycle_sequencer #(.CNT_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    int total = 0;
    int bad = 0;
    int ncyc;
    logic [W-1:0] cnt_m = '0;
    logic [10+W-1:0] q[$];
    function automatic logic [9:0] ev(input logic a, b, c, d, e, f, g, input logic [2:0] s);
        return {a, b, c, d, e, f, g, s};
    endfunction
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [4:0] rop();
        return 5'($urandom_range(0, 31));
    endfunction
    // 0 NOP, 1 ALU, 2 COMPARE, 3 BRANCH, 4 LOAD, 5 STORE
    function automatic int cls(input logic [4:0] op);
        if (op == 5'b10001) return 3;
        if (op == 5'b10010) return 4;
        if (op == 5'b10011) return 5;
        if (op == 5'b01010 || op == 5'b01000) return 2;
        return op[4] ? 0 : 1;
    endfunction
    task automatic step(input logic rs, ir, dr, input logic [4:0] op, input logic ce, input logic [9:0] e);
        @(posedge clk);
        #1;
        reset = rs;
        bus.imemReady = ir;
        bus.dmemReady = dr;
        bus.opcode = op;
        bus.conditionalExecute = ce;
        q.push_back({e, cnt_m});
        ncyc++;
    endtask
    task automatic pin(input string n, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask
    task automatic run(input logic [4:0] op, input logic ce, input int is, input int ds, input int abort);
        int c;
        logic ld, st;
        c = cls(op);
        ld = c == 4;
        st = c == 5;
        ncyc = 0;
        for (int i = 0; i < is; i++) step(0, 0, rb(), rop(), rb(), ev(1, 0, 0, 0, 0, 0, 0, 1));
        step(0, 1, rb(), rop(), rb(), ev(1, 1, 0, 0, 0, 0, 0, 1));
        step(0, rb(), rb(), op, ce, ev(0, 0, !ce, 0, 0, 0, 0, 2));
        if (!ce) return;
        step(0, rb(), rb(), rop(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 3));
        if (ld || st) begin
            for (int i = 0; i <= ds; i++) begin
                if (i == abort) begin
                    step(1, rb(), rb(), rop(), rb(), ev(0, 0, 0, 0, ld, st, 0, 4));
                    cnt_m = '0;
                    step(1, rb(), rb(), rop(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0));
                    step(0, rb(), rb(), rop(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0));
                    return;
                end
                step(0, rb(), i == ds, rop(), rb(), ev(0, 0, 0, 0, ld, st, 0, 4));
            end
        end
        step(0, rb(), rb(), rop(), rb(), ev(0, 0, c != 3, c == 3, 0, 0, c == 1 || c == 4, 5));
        cnt_m++;
    endtask
    task automatic pin_fetch(input string n, input int exp);
        step(0, 0, rb(), rop(), rb(), ev(1, 0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        #1;
        pin({n, "_state"}, int'(bus.state), 1);
        pin(n, int'(bus.retiredCount), exp);
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [10+W-1:0] e, g;
            e = q.pop_front();
            g = {bus.imemRead, bus.irLoad, bus.pcIncrement, bus.pcLoadBranch, bus.dmemRead,
                 bus.dmemWrite, bus.aluWritebackTest, bus.state, bus.retiredCount};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL trace t=%0t: got ir/il/pi/pb/dr/dw/aw=%b state=%0d cnt=%0d expected %b state=%0d cnt=%0d",
                         $time, g[10+W-1:W+3], g[W+2:W], g[W-1:0], e[10+W-1:W+3], e[W+2:W], e[W-1:0]);
            end
        end
    end
    initial begin
        bus.imemReady = 1'b0;
        bus.dmemReady = 1'b0;
        bus.opcode = 5'd0;
        bus.conditionalExecute = 1'b0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 5'd0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        pin("reset_state", int'(bus.state), 0);
        pin("reset_cnt", int'(bus.retiredCount), 0);
        run(5'b00100, 1, 0, 0, -1);
        pin("alu_lat", ncyc, 4);
        pin_fetch("alu_cnt", 1);
        run(5'b10001, 1, 0, 0, -1);
        pin("br_lat", ncyc, 4);
        run(5'b10001, 0, 0, 0, -1);
        pin("squash_lat", ncyc, 2);
        pin_fetch("br_cnt", 2);
        run(5'b10010, 1, 0, 3, -1);
        pin("ld_stall_lat", ncyc, 8);
        run(5'b10011, 1, 0, 0, -1);
        pin("st_lat", ncyc, 5);
        run(5'b00100, 1, 5, 0, -1);
        pin("fetch_stall_lat", ncyc, 9);
        pin_fetch("mem_cnt", 5);
        run(5'b10010, 1, 0, 5, 2);
        @(negedge clk);
        #1;
        pin("abort_cnt", int'(bus.retiredCount), 0);
        while (cnt_m != {W{1'b1}}) run(5'b11111, 1, 0, 0, -1);
        pin_fetch("wrap_pre", (1 << W) - 1);
        run(5'b11111, 1, 0, 0, -1);
        pin_fetch("wrap_post", 0);
        for (int n = 0; n < 300; n++) begin
            logic [4:0] op;
            int k, ds, ab;
            k = $urandom_range(0, 5);
            op = k == 0 ? 5'b10001 : k == 1 ? 5'b10010 : k == 2 ? 5'b10011 :
                 k == 3 ? ($urandom_range(0, 1) ? 5'b01010 : 5'b01000) : rop();
            ds = $urandom_range(0, 3);
            ab = $urandom_range(0, 19) == 0 ? int'($urandom_range(0, ds)) : -1;
            run(op, $urandom_range(0, 3) != 0, $urandom_range(0, 3), ds, ab);
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
